// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative RV32M multiply/divide unit that sits beside the execute-stage
// ALU. Execute issues an OP instruction with funct7 = 0000001 by pulsing
// start while the unit is idle. The unit freezes the pipeline through
// halt_req, iterates on unsigned magnitudes (shift-add multiply or restoring
// divide, one bit per cycle) and returns the sign-corrected result with a
// one-cycle done strobe. A taken branch aborts the operation through kill.
//
// Handshake: start is accepted only in IDLE with kill low. From that cycle
// until the cycle before done, halt_req stays high. done is high for exactly
// one cycle and result holds its value until the next done. An operation
// killed in MUL/DIV produces no done and leaves result untouched.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   defined   - multiplies use one 33x33 signed multiply; MUL lasts one cycle
//               (start in cycle 0, done in cycle 2).
//   undefined - 32-iteration radix-2 shift-add multiply (done in cycle 33).
//   Divides always take the 32-iteration restoring path.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   start     in   issue strobe, sampled only in IDLE
//   funct3    in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                  100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1       in   operand A (multiplicand / dividend)
//   rs2       in   operand B (multiplier / divisor)
//   kill      in   flush of the in-flight operation
//   busy      out  registered, high while in MUL or DIV
//   halt_req  out  combinational pipeline freeze request
//   done      out  registered one-cycle result strobe
//   result    out  registered result, stable between done strobes
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN      = 32,
    parameter int ITER_BITS = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            halt_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]      MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]      ALL_ONES = {XLEN{1'b1}};
    localparam logic [ITER_BITS-1:0] LAST_IT  = ITER_BITS'(XLEN - 1);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [2:0]            op_q;      // latched funct3
    logic [XLEN-1:0]       opnd_q;    // multiplicand or divisor, held constant
    logic [2*XLEN-1:0]     acc_q, acc_d;  // {hi, lo} product or {rem, quot}
    logic                  neg_q;     // result needs two's-complement fixup
    logic [ITER_BITS-1:0]  cnt_q, cnt_d;
    logic                  busy_d;
    logic                  done_d;
    logic [XLEN-1:0]       result_d;
    logic                  load;      // accept the issued operation

    // -----------------------------------------------------------------------
    // Issue-time decode of the incoming operation
    // -----------------------------------------------------------------------
    logic            is_div;
    logic            signed_a, signed_b;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            sign_in;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        is_div   = funct3[2];
        // Unsigned variants: MULHU (011), DIVU (101), REMU (111).
        // MULHSU (010) treats only rs1 as signed.
        signed_a = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        signed_b = signed_a && (funct3 != 3'b010);
        neg_a    = signed_a & rs1[XLEN-1];
        neg_b    = signed_b & rs2[XLEN-1];
        mag_a    = neg_a ? -rs1 : rs1;
        mag_b    = neg_b ? -rs2 : rs2;
        // Remainder takes the dividend's sign; quotient and product take
        // the exclusive-or of both operand signs.
        sign_in  = (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);

        div_zero = is_div && (rs2 == '0);
        div_ovf  = is_div && !funct3[0] && (rs1 == MIN_INT) && (rs2 == ALL_ONES);
        if (div_zero) begin
            fast_res = funct3[1] ? rs1 : ALL_ONES;
        end else begin
            fast_res = funct3[1] ? '0 : MIN_INT;
        end
    end

    // -----------------------------------------------------------------------
    // One iteration of each algorithm
    // -----------------------------------------------------------------------
    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit (acc LSB) is set, then shift the whole register right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
    end

    // Restoring divide: shift {rem, quot} left by one and subtract the
    // divisor when it fits. The shifted partial remainder needs XLEN+1 bits,
    // but the kept remainder is always below the divisor, so the subtraction
    // itself can be done at XLEN bits.
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
    end

`ifdef MULDIV_FAST_MUL_EN
    // Operands are already magnitudes; the zero extension keeps the signed
    // multiplier from reinterpreting bit XLEN-1 as a sign bit.
    logic signed [2*XLEN+1:0] fast_prod;
    assign fast_prod = $signed({1'b0, opnd_q}) * $signed({1'b0, acc_q[XLEN-1:0]});
`endif

    // Sign fixup and word selection applied to the final accumulator.
    function automatic logic [XLEN-1:0] fixup(input logic [2*XLEN-1:0] acc,
                                              input logic [2:0]        op,
                                              input logic              neg);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   word;
        prod = neg ? -acc : acc;
        word = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (op[2]) begin
            return neg ? -word : word;
        end else if (op[1:0] == 2'b00) begin
            return prod[XLEN-1:0];
        end else begin
            return prod[2*XLEN-1:XLEN];
        end
    endfunction

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result;
        load     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    acc_d = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    if (div_zero || div_ovf) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = fast_res;
                    end else begin
                        state_d = is_div ? S_DIV : S_MUL;
                        busy_d  = 1'b1;
                    end
                end
            end

            S_MUL: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
`ifdef MULDIV_FAST_MUL_EN
                    acc_d    = fast_prod[2*XLEN-1:0];
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = fixup(acc_d, op_q, neg_q);
`else
                    acc_d = mul_next;
                    cnt_d = cnt_q + ITER_BITS'(1);
                    if (cnt_q == LAST_IT) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = fixup(acc_d, op_q, neg_q);
                    end else begin
                        busy_d = 1'b1;
                    end
`endif
                end
            end

            S_DIV: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q + ITER_BITS'(1);
                    if (cnt_q == LAST_IT) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = fixup(acc_d, op_q, neg_q);
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end

            // The strobe is already on the output; kill here does not
            // retract it, execute simply discards the result.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            result  <= result_d;
            if (load) begin
                op_q   <= funct3;
                opnd_q <= is_div ? mag_b : mag_a;
                neg_q  <= sign_in;
            end
        end
    end

    // Freeze starts in the issue cycle itself so execute holds the
    // instruction while the unit is working.
    assign halt_req = (start && (state_q == S_IDLE) && !kill) || busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer. Directed vectors cover the main
// operations, divide fast paths, kill, mid-operation reset and ignored
// starts; a randomized section compares against an arithmetic reference
// model. Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 2 time units after it.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam logic [31:0] MIN_INT  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        kill = 1'b0;
    logic        busy;
    logic        halt_req;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    muldiv_sequencer #(.XLEN(32), .ITER_BITS(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1      (rs1),
        .rs2      (rs2),
        .kill     (kill),
        .busy     (busy),
        .halt_req (halt_req),
        .done     (done),
        .result   (result)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------ reference model
    function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return ALL_ONES;
                if (a == MIN_INT && b == ALL_ONES) return MIN_INT;
                return $signed(a) / $signed(b);
            end
            3'b101: begin
                if (b == 0) return ALL_ONES;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == ALL_ONES) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from the issue cycle to the done cycle.
    function automatic int exp_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0 || (!f3[0] && a == MIN_INT && b == ALL_ONES)) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 2;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return MIN_INT;
            2:       return ALL_ONES;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // --------------------------------------------------------------- driver
    // Called at drive time of the issue cycle. Returns the observed latency
    // (-1 on timeout), the result seen with done, and the number of cycles
    // where halt_req/busy did not match the expected freeze window.
    task automatic do_op(input  logic [2:0]  f3,
                         input  logic [31:0] a,
                         input  logic [31:0] b,
                         output int          lat,
                         output logic [31:0] res,
                         output int          halt_bad);
        halt_bad = 0;
        lat      = -1;
        res      = '0;
        start    = 1'b1;
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        #1;
        if (halt_req !== 1'b1) halt_bad++;
        for (int c = 1; c <= 100; c++) begin
            step();
            start = 1'b0;
            #1;
            if (done === 1'b1) begin
                lat = c;
                res = result;
                if (halt_req !== 1'b0 || busy !== 1'b0) halt_bad++;
                break;
            end
            if (halt_req !== 1'b1 || busy !== 1'b1) halt_bad++;
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++; if (halt_req !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b want 0", halt_req); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat, hb;
        logic [31:0] res;
        step();
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, lat, res, hb);
        n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_7_m3 got %h want ffffffeb", res); end
        n_checks++; if (lat != exp_lat(3'b000, 32'd7, 32'hFFFF_FFFD)) begin n_fail++; $display("FAIL mul_latency got %0d want %0d", lat, exp_lat(3'b000, 32'd7, 32'hFFFF_FFFD)); end
        n_checks++; if (hb != 0) begin n_fail++; $display("FAIL mul_halt_window got %0d bad cycles want 0", hb); end
        step();
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", done); end
        n_checks++; if (result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL result_hold got %h want ffffffeb", result); end

        step();
        do_op(3'b011, ALL_ONES, ALL_ONES, lat, res, hb);
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_ones got %h want fffffffe", res); end
        step();
        do_op(3'b001, ALL_ONES, ALL_ONES, lat, res, hb);
        n_checks++; if (res !== 32'h0000_0000) begin n_fail++; $display("FAIL mulh_ones got %h want 00000000", res); end
        step();
        do_op(3'b010, ALL_ONES, 32'd2, lat, res, hb);
        n_checks++; if (res !== ALL_ONES) begin n_fail++; $display("FAIL mulhsu_m1x2 got %h want ffffffff", res); end
    endtask

    task automatic test_div();
        int lat, hb;
        logic [31:0] res;
        step();
        do_op(3'b100, 32'hFFFF_FFEC, 32'd3, lat, res, hb);
        n_checks++; if (res !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL div_m20_3 got %h want fffffffa", res); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div_latency got %0d want 33", lat); end
        n_checks++; if (hb != 0) begin n_fail++; $display("FAIL div_halt_window got %0d bad cycles want 0", hb); end
        step();
        do_op(3'b110, 32'hFFFF_FFEC, 32'd3, lat, res, hb);
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rem_m20_3 got %h want fffffffe", res); end
        step();
        do_op(3'b101, 32'd100, 32'd7, lat, res, hb);
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_100_7 got %h want 0000000e", res); end
    endtask

    task automatic test_div_fast_paths();
        int lat, hb;
        logic [31:0] res;
        step();
        do_op(3'b101, 32'd5, 32'd0, lat, res, hb);
        n_checks++; if (res !== ALL_ONES) begin n_fail++; $display("FAIL divu_by_zero got %h want ffffffff", res); end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL div0_latency got %0d want 1", lat); end
        n_checks++; if (hb != 0) begin n_fail++; $display("FAIL div0_halt got %0d bad cycles want 0", hb); end
        step();
        do_op(3'b111, 32'd5, 32'd0, lat, res, hb);
        n_checks++; if (res !== 32'd5) begin n_fail++; $display("FAIL remu_by_zero got %h want 00000005", res); end
        step();
        do_op(3'b100, MIN_INT, ALL_ONES, lat, res, hb);
        n_checks++; if (res !== MIN_INT) begin n_fail++; $display("FAIL div_overflow got %h want 80000000", res); end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL ovf_latency got %0d want 1", lat); end
        step();
        do_op(3'b110, MIN_INT, ALL_ONES, lat, res, hb);
        n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL rem_overflow got %h want 00000000", res); end
    endtask

    task automatic test_kill();
        int lat, hb, early_done;
        logic [31:0] res;
        step();
        do_op(3'b101, 32'd100, 32'd7, lat, res, hb);
        step();
        // cycle 0: issue a DIV that gets squashed in cycle 10
        start = 1'b1; funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3;
        early_done = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
            if (c == 10) kill = 1'b1;
            #1;
            if (done === 1'b1) early_done++;
        end
        step();
        kill = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0 || early_done != 0) begin n_fail++; $display("FAIL kill_no_done got %b/%0d want 0/0", done, early_done); end
        n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL kill_result_hold got %h want 0000000e", result); end
        step();
        do_op(3'b100, 32'd1000, 32'hFFFF_FFFD, lat, res, hb);
        n_checks++; if (res !== 32'hFFFF_FEB3) begin n_fail++; $display("FAIL after_kill_div got %h want fffffeb3", res); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL after_kill_latency got %0d want 33", lat); end
    endtask

    task automatic test_reset_mid_op();
        int stray_done;
        step();
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd123; rs2 = 32'd456;
        for (int c = 1; c <= 15; c++) begin
            step();
            start = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", result); end
        stray_done = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            #1;
            if (done === 1'b1 || halt_req !== 1'b0) stray_done++;
        end
        n_checks++; if (stray_done != 0) begin n_fail++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", stray_done); end
    endtask

    task automatic test_ignored_start();
        int lat, el;
        logic [31:0] res;
        el  = exp_lat(3'b011, ALL_ONES, ALL_ONES);
        lat = -1;
        res = '0;
        step();
        start = 1'b1; funct3 = 3'b011; rs1 = ALL_ONES; rs2 = ALL_ONES;
        for (int c = 1; c <= 100; c++) begin
            step();
            // keep hammering start with a different op until the done cycle
            if (c <= el) begin
                start = 1'b1; funct3 = 3'b101; rs1 = $urandom; rs2 = 32'd1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done === 1'b1) begin
                lat = c;
                res = result;
                break;
            end
        end
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL busy_start_result got %h want fffffffe", res); end
        n_checks++; if (lat != el) begin n_fail++; $display("FAIL busy_start_latency got %0d want %0d", lat, el); end
        step();
        start = 1'b0;
        step();
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL busy_start_queued got busy=%b done=%b want 0/0", busy, done); end

        // start together with kill in IDLE is dropped
        step();
        start = 1'b1; kill = 1'b1; funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd0;
        #1;
        n_checks++; if (halt_req !== 1'b0) begin n_fail++; $display("FAIL start_kill_halt got %b want 0", halt_req); end
        step();
        start = 1'b0; kill = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL start_kill_ignored got busy=%b done=%b want 0/0", busy, done); end
        n_checks++; if (result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL start_kill_result got %h want fffffffe", result); end
    endtask

    task automatic test_random();
        int lat, hb;
        logic [31:0] res, a, b, exp_v;
        logic [2:0]  f3;
        for (int i = 0; i < 48; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = rand_word();
            b  = rand_word();
            exp_q.push_back(ref_model(f3, a, b));
            step();
            do_op(f3, a, b, lat, res, hb);
            exp_v = exp_q.pop_front();
            n_checks++; if (res !== exp_v) begin n_fail++; $display("FAIL rand_result op=%0d a=%h b=%h got %h want %h", f3, a, b, res, exp_v); end
            n_checks++; if (lat != exp_lat(f3, a, b)) begin n_fail++; $display("FAIL rand_latency op=%0d got %0d want %0d", f3, lat, exp_lat(f3, a, b)); end
            n_checks++; if (hb != 0) begin n_fail++; $display("FAIL rand_halt op=%0d got %0d bad cycles want 0", f3, hb); end
        end
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_fast_paths();
        test_kill();
        test_reset_mid_op();
        test_ignored_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
